uart_rx_frame_decoder: RTL and testbench

- Passive serial-side decoder that consumes the UART serial net (uart_0to1 / uart_1to0) watched by the UART protocol checker.
- Recovers each transmitted frame and emits a one-cycle record: data, parity error, stop error, break, false start.
- The checker and scoreboard compare this record against APB-side writes.
- Never drives the line; one instance per serial net, clocked by that side's pclk.

---
 rtl/uart_rx_dec_pkg.sv | 34 +++
 rtl/uart_rx_frame_decoder_timer.sv | 38 +++
 rtl/uart_rx_frame_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_frame_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_dec_pkg.sv
// Shared definitions for the passive UART frame decoder: FSM state codes,
// data-length encodings, default minimum divisor and the data-length helper.
package uart_rx_dec_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP1   = 3'd4;
  localparam logic [2:0] ST_STOP2   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_WAIT_HI = 3'd7;

  localparam logic [1:0] DLEN_5 = 2'b00;
  localparam logic [1:0] DLEN_6 = 2'b01;
  localparam logic [1:0] DLEN_7 = 2'b10;
  localparam logic [1:0] DLEN_8 = 2'b11;

  localparam int MIN_DIV_DEFAULT = 4;

  // Number of data bits carried by a frame for a given cfg_dlen code.
  function automatic logic [3:0] dlen_bits(input logic [1:0] dlen);
    logic [3:0] n;
    case (dlen)
      DLEN_5:  n = 4'd5;
      DLEN_6:  n = 4'd6;
      DLEN_7:  n = 4'd7;
      DLEN_8:  n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_frame_decoder_timer.sv
// Bit-period timer: captures the clamped divisor at start detect, first
// counts half a bit (to land mid-bit), then strobes once per bit period.
module uart_rx_bit_timer #(
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign div_eff = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;

  // The strobe cycle is the one in which the count expires; reload there.
  assign strobe = run && !start && (cnt_q <= DIV_W'(1));

  // Half-bit load on start, then free-running period reload while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      div_q <= div_eff;
      cnt_q <= div_eff >> 1;
    end else if (run) begin
      if (cnt_q <= DIV_W'(1)) cnt_q <= div_q;
      else                    cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// Passive UART serial-side frame decoder. Watches one serial net and emits a
// one-cycle record per recovered frame (data, parity/stop error, break) plus
// a false-start pulse for start bits that are not low at mid-bit.
// Optional build macro UART_RX_DEC_MAJORITY_EN: 2-of-3 majority sampling
// around each strobe, with every decision applied one pclk later.
module uart_rx_frame_decoder
  import uart_rx_dec_pkg::*;
#(
  parameter int    DIV_W    = 16,
  parameter int    MIN_DIV  = MIN_DIV_DEFAULT,
  parameter string DBG_NAME = "uart_dec"
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             uart_net,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_dlen,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  output logic             busy,
  output logic             frame_valid,
  output logic [7:0]       frame_data,
  output logic             parity_err,
  output logic             stop_err,
  output logic             break_det,
  output logic             false_start
);

  // Name exists only to tag simulation messages; an empty name gets no block.
  if (DBG_NAME == "") begin : g_no_dbg_name
  end

  logic       sync_q, rx_s, rx_prev, fall;
  logic [2:0] state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] dat_q;
  logic       perr_q, serr_q, par_bit_q, stop1_low_q;
  logic [1:0] sh_dlen;
  logic       sh_par_en, sh_par_odd, sh_stop2;
  logic       start_det, run, strobe, evt, smp;
  logic       last_bit, last_stop, serr_nxt, stop1_low_nxt;

  // 2-FF synchroniser plus one history flop for edge detect (idle high).
  always_ff @(posedge pclk) begin
    if (preset) begin
      sync_q  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= uart_net;
      rx_s    <= sync_q;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign start_det = (state_q == ST_IDLE) && fall;
  assign busy      = (state_q != ST_IDLE);
  assign run       = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP1) ||
                     (state_q == ST_STOP2);

  uart_rx_bit_timer #(
    .DIV_W   (DIV_W),
    .MIN_DIV (MIN_DIV)
  ) u_timer (
    .clk    (pclk),
    .rst    (preset),
    .start  (start_det),
    .run    (run),
    .div    (cfg_div),
    .strobe (strobe)
  );

`ifdef UART_RX_DEC_MAJORITY_EN
  logic strobe_q, smp_a, smp_b;

  // Hold the strobe-1 and strobe samples; vote with rx_s one cycle later.
  always_ff @(posedge pclk) begin
    if (preset) begin
      strobe_q <= 1'b0;
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
    end else begin
      strobe_q <= strobe;
      if (strobe) begin
        smp_a <= rx_prev;
        smp_b <= rx_s;
      end
    end
  end

  assign evt = strobe_q;
  assign smp = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
`else
  assign evt = strobe;
  assign smp = rx_s;
`endif

  assign last_bit      = ({1'b0, bit_cnt_q} == (dlen_bits(sh_dlen) - 4'd1));
  assign last_stop     = evt && (((state_q == ST_STOP1) && !sh_stop2) ||
                                 (state_q == ST_STOP2));
  assign serr_nxt      = serr_q | ~smp;
  assign stop1_low_nxt = (state_q == ST_STOP1) ? ~smp : stop1_low_q;

  // Frame FSM: start qualification, data shift, parity and stop checks.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      dat_q       <= '0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      par_bit_q   <= 1'b0;
      stop1_low_q <= 1'b0;
      sh_dlen     <= DLEN_8;
      sh_par_en   <= 1'b0;
      sh_par_odd  <= 1'b0;
      sh_stop2    <= 1'b0;
      false_start <= 1'b0;
    end else begin
      false_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q     <= ST_START;
            sh_dlen     <= cfg_dlen;
            sh_par_en   <= cfg_par_en;
            sh_par_odd  <= cfg_par_odd;
            sh_stop2    <= cfg_stop2;
            bit_cnt_q   <= '0;
            dat_q       <= '0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
            par_bit_q   <= 1'b0;
            stop1_low_q <= 1'b0;
          end
        end
        ST_START: begin
          if (evt) begin
            if (smp) begin
              false_start <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
        end
        ST_DATA: begin
          if (evt) begin
            dat_q[bit_cnt_q] <= smp;
            bit_cnt_q        <= bit_cnt_q + 3'd1;
            if (last_bit) state_q <= sh_par_en ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (evt) begin
            par_bit_q <= smp;
            perr_q    <= ((^dat_q) ^ smp) != sh_par_odd;
            state_q   <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (evt) begin
            serr_q      <= serr_nxt;
            stop1_low_q <= stop1_low_nxt;
            state_q     <= sh_stop2 ? ST_STOP2 : ST_DONE;
          end
        end
        ST_STOP2: begin
          if (evt) begin
            serr_q  <= serr_nxt;
            state_q <= ST_DONE;
          end
        end
        ST_DONE:    state_q <= rx_s ? ST_IDLE : ST_WAIT_HI;
        ST_WAIT_HI: if (rx_s) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Publish the frame record on the final stop strobe; hold between pulses.
  always_ff @(posedge pclk) begin
    if (preset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      parity_err  <= 1'b0;
      stop_err    <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      frame_valid <= last_stop;
      if (last_stop) begin
        frame_data <= dat_q;
        parity_err <= perr_q;
        stop_err   <= serr_nxt;
        break_det  <= (dat_q == 8'h00) && !par_bit_q && stop1_low_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed bench for uart_rx_frame_decoder: drives the serial line bit by bit
// on falling pclk edges and checks each recovered frame record.
module tb_uart_rx_frame_decoder;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        uart_net = 1'b1;
  logic [15:0] cfg_div = 16'd16;
  logic [1:0]  cfg_dlen = 2'b11;
  logic        cfg_par_en = 1'b0;
  logic        cfg_par_odd = 1'b0;
  logic        cfg_stop2 = 1'b0;
  logic        busy, frame_valid, parity_err, stop_err, break_det, false_start;
  logic [7:0]  frame_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fs_cnt = 0;
  int fv_cyc = 0;
  int start_cyc = 0;

  uart_rx_frame_decoder dut (
    .pclk        (pclk),
    .preset      (preset),
    .uart_net    (uart_net),
    .cfg_div     (cfg_div),
    .cfg_dlen    (cfg_dlen),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .parity_err  (parity_err),
    .stop_err    (stop_err),
    .break_det   (break_det),
    .false_start (false_start)
  );

  // Clock and cycle counter
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge pclk) begin
    if (frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
    if (false_start) fs_cnt = fs_cnt + 1;
  end

  task automatic drive_bit(input logic b, input int div);
    uart_net = b;
    repeat (div) @(negedge pclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits,
                            input logic par_on, input logic par_val,
                            input logic s1, input logic s2_on, input logic s2,
                            input int div);
    start_cyc = cyc;
    drive_bit(1'b0, div);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], div);
    if (par_on) drive_bit(par_val, div);
    drive_bit(s1, div);
    if (s2_on) drive_bit(s2, div);
    drive_bit(1'b1, 2 * div);
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (4) @(negedge pclk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_checks++; if (frame_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got %h want 00", frame_data); end
    n_checks++; if ({parity_err, stop_err, break_det, false_start} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags got %b want 0000", {parity_err, stop_err, break_det, false_start}); end
    preset = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic test_nominal();
    int fv0, lat;
    cfg_div = 16'd16; cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    fv0 = fv_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    lat = fv_cyc - start_cyc;
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL nominal_count got %0d want 1", fv_cnt - fv0); end
    n_checks++; if (frame_data !== 8'hA5) begin n_errors++; $display("FAIL nominal_data got %h want a5", frame_data); end
    n_checks++; if ({parity_err, stop_err, break_det} !== 3'b000) begin n_errors++; $display("FAIL nominal_flags got %b want 000", {parity_err, stop_err, break_det}); end
    n_checks++; if (lat < 150 || lat > 160) begin n_errors++; $display("FAIL nominal_latency got %0d want 150..160", lat); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL nominal_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_parity();
    cfg_div = 16'd8; cfg_dlen = 2'b10; cfg_par_en = 1'b1; cfg_par_odd = 1'b1; cfg_stop2 = 1'b0;
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8);
    n_checks++; if (parity_err !== 1'b1) begin n_errors++; $display("FAIL parity_bad got %b want 1", parity_err); end
    n_checks++; if (frame_data !== 8'h55) begin n_errors++; $display("FAIL parity_data got %h want 55", frame_data); end
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8);
    n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL parity_good got %b want 0", parity_err); end
    n_checks++; if (stop_err !== 1'b0) begin n_errors++; $display("FAIL parity_stop got %b want 0", stop_err); end
  endtask

  task automatic test_five_bit_two_stop();
    int fv0, lat;
    cfg_div = 16'd16; cfg_dlen = 2'b00; cfg_par_en = 1'b0; cfg_stop2 = 1'b1;
    fv0 = fv_cnt;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16);
    lat = fv_cyc - start_cyc;
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL stop2_count got %0d want 1", fv_cnt - fv0); end
    n_checks++; if (frame_data !== 8'h1F) begin n_errors++; $display("FAIL stop2_data got %h want 1f", frame_data); end
    n_checks++; if (stop_err !== 1'b1) begin n_errors++; $display("FAIL stop2_err got %b want 1", stop_err); end
    n_checks++; if (break_det !== 1'b0) begin n_errors++; $display("FAIL stop2_break got %b want 0", break_det); end
    n_checks++; if (lat < 119 || lat > 128) begin n_errors++; $display("FAIL stop2_latency got %0d want 119..128", lat); end
  endtask

  task automatic test_glitch();
    int fv0, fs0;
    cfg_div = 16'd16; cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    fv0 = fv_cnt; fs0 = fs_cnt;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 48);
    n_checks++; if (fs_cnt - fs0 !== 1) begin n_errors++; $display("FAIL glitch_fs got %0d want 1", fs_cnt - fs0); end
    n_checks++; if (fv_cnt - fv0 !== 0) begin n_errors++; $display("FAIL glitch_fv got %0d want 0", fv_cnt - fv0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy got %b want 0", busy); end
  endtask

  task automatic test_break();
    int fv0;
    cfg_div = 16'd16; cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    fv0 = fv_cnt;
    drive_bit(1'b0, 30 * 16);
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL break_count got %0d want 1", fv_cnt - fv0); end
    n_checks++; if (frame_data !== 8'h00) begin n_errors++; $display("FAIL break_data got %h want 00", frame_data); end
    n_checks++; if ({stop_err, break_det} !== 2'b11) begin n_errors++; $display("FAIL break_flags got %b want 11", {stop_err, break_det}); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL break_waithi got busy=%b want 1", busy); end
    drive_bit(1'b1, 32);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL break_release got busy=%b want 0", busy); end
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL break_single got %0d want 1", fv_cnt - fv0); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0, fs0;
    cfg_div = 16'd16; cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    fv0 = fv_cnt; fs0 = fs_cnt;
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    preset = 1'b1; uart_net = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (200) @(negedge pclk);
    n_checks++; if (fv_cnt - fv0 !== 0 || fs_cnt - fs0 !== 0) begin n_errors++; $display("FAIL rstmid_pulses got fv=%0d fs=%0d want 0 0", fv_cnt - fv0, fs_cnt - fs0); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL rstmid_count got %0d want 1", fv_cnt - fv0); end
    n_checks++; if (frame_data !== 8'h3C || stop_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_data got %h/%b want 3c/0", frame_data, stop_err); end
  endtask

  task automatic test_cfg_hold();
    int fv0;
    cfg_div = 16'd16; cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    fv0 = fv_cnt;
    fork
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
      begin
        repeat (40) @(negedge pclk);
        cfg_dlen = 2'b00; cfg_par_en = 1'b1; cfg_stop2 = 1'b1; cfg_div = 16'd5;
      end
    join
    n_checks++; if (fv_cnt - fv0 !== 1) begin n_errors++; $display("FAIL cfghold_count got %0d want 1", fv_cnt - fv0); end
    n_checks++; if (frame_data !== 8'hC3 || {parity_err, stop_err} !== 2'b00) begin n_errors++; $display("FAIL cfghold_data got %h/%b want c3/00", frame_data, {parity_err, stop_err}); end
    cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0; cfg_div = 16'd16;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity();
    test_five_bit_two_stop();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_cfg_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
